move_judge: RTL and testbench

- Consumer side of the dance-move sequence interface. It requests moves from the move generator, holds each one as the expected arrow, and judges the player's button presses against it inside a timing window.
- It keeps the hit, miss and combo statistics and signals game-over once the generator's last move has been judged.
- It sits between the move generator, the four debounced arrow buttons, and the display/score logic.

---
 rtl/ddr_pkg.sv | 29 ++
 rtl/btn_edge_sync.sv | 28 ++
 rtl/move_judge.sv | 129 ++++++++++++
 tb/tb_move_judge.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared definitions for the dance-move judge: arrow codes, judge state
// encoding, score width and a saturating score increment.
package ddr_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'd0;
    localparam dir_t DIR_DOWN  = 2'd1;
    localparam dir_t DIR_LEFT  = 2'd2;
    localparam dir_t DIR_RIGHT = 2'd3;

    localparam int SCORE_W = 8;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_CLEAR   = 4'd1;
    localparam logic [3:0] ST_FETCH   = 4'd2;
    localparam logic [3:0] ST_SETTLE1 = 4'd3;
    localparam logic [3:0] ST_SETTLE2 = 4'd4;
    localparam logic [3:0] ST_ARMED   = 4'd5;
    localparam logic [3:0] ST_RESULT  = 4'd6;
    localparam logic [3:0] ST_GAP     = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;

    // Scores stick at full scale instead of wrapping back to zero.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Brings one asynchronous debounced button into the clk domain and flags
// its rising edge for exactly one cycle.
module btn_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic meta;
    logic sync;
    logic sync_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= btn;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;

endmodule

// File: rtl/move_judge.sv
// Requests moves from the generator, arms each one as the expected arrow and
// judges button presses against it, keeping hit/miss/combo statistics.
module move_judge
    import ddr_pkg::*;
#(
    parameter int WINDOW_CYCLES = 25_000_000,
    parameter int GAP_CYCLES    = 12_500_000,
    parameter int CNT_W         = 25
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic [1:0]         move_in,
    input  logic               end_move_in,
    output logic               get_move,
    output logic               gen_reset,
    output logic [1:0]         expected_move,
    output logic               armed,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] hits,
    output logic [SCORE_W-1:0] misses,
    output logic [SCORE_W-1:0] combo,
    output logic [SCORE_W-1:0] max_combo,
    output logic               done
);

    logic [3:0]         state;
    logic [3:0]         next_state;
    logic [CNT_W-1:0]   cnt;
    logic               last_flag;
    logic               verdict_hit;
    logic [3:0]         edges;
    logic               any_edge;
    logic               hit_now;
    logic               timeout;
    logic               gap_end;
    logic [SCORE_W-1:0] combo_inc;

    // Edge vector bit index equals the arrow code it belongs to.
    btn_edge_sync u_sync_up    (.clk(clk), .reset(reset), .btn(btn_up),    .rise(edges[DIR_UP]));
    btn_edge_sync u_sync_down  (.clk(clk), .reset(reset), .btn(btn_down),  .rise(edges[DIR_DOWN]));
    btn_edge_sync u_sync_left  (.clk(clk), .reset(reset), .btn(btn_left),  .rise(edges[DIR_LEFT]));
    btn_edge_sync u_sync_right (.clk(clk), .reset(reset), .btn(btn_right), .rise(edges[DIR_RIGHT]));

    assign any_edge  = |edges;
    assign hit_now   = (edges == (4'b0001 << expected_move));
    assign timeout   = (cnt == CNT_W'(WINDOW_CYCLES - 1));
    assign gap_end   = (cnt == CNT_W'(GAP_CYCLES - 1));
    assign combo_inc = sat_inc(combo);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (start) next_state = ST_CLEAR;
            ST_CLEAR:   next_state = ST_FETCH;
            ST_FETCH:   next_state = ST_SETTLE1;
            ST_SETTLE1: next_state = ST_SETTLE2;
            ST_SETTLE2: next_state = ST_ARMED;
            ST_ARMED:   if (any_edge || timeout) next_state = ST_RESULT;
            ST_RESULT:  next_state = last_flag ? ST_DONE : ST_GAP;
            ST_GAP:     if (gap_end) next_state = ST_FETCH;
            ST_DONE:    if (start) next_state = ST_CLEAR;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Request and generator-reset are registered off the next state so they
    // line up exactly with the FETCH / IDLE+CLEAR cycles without glitches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            get_move      <= 1'b0;
            gen_reset     <= 1'b1;
            expected_move <= DIR_UP;
            last_flag     <= 1'b0;
            verdict_hit   <= 1'b0;
            hits          <= '0;
            misses        <= '0;
            combo         <= '0;
            max_combo     <= '0;
        end else begin
            state     <= next_state;
            get_move  <= (next_state == ST_FETCH);
            gen_reset <= (next_state == ST_IDLE) || (next_state == ST_CLEAR);
            case (state)
                ST_CLEAR: begin
                    hits      <= '0;
                    misses    <= '0;
                    combo     <= '0;
                    max_combo <= '0;
                end
                ST_SETTLE2: begin
                    expected_move <= move_in;
                    last_flag     <= end_move_in;
                    cnt           <= '0;
                end
                ST_ARMED: begin
                    cnt         <= cnt + 1'b1;
                    verdict_hit <= any_edge && hit_now;
                end
                ST_RESULT: begin
                    cnt <= '0;
                    if (verdict_hit) begin
                        hits  <= sat_inc(hits);
                        combo <= combo_inc;
                        if (combo_inc > max_combo) max_combo <= combo_inc;
                    end else begin
                        misses <= sat_inc(misses);
                        combo  <= '0;
                    end
                end
                ST_GAP: cnt <= cnt + 1'b1;
                default: ;
            endcase
        end
    end

    assign armed      = (state == ST_ARMED);
    assign hit_pulse  = (state == ST_RESULT) &&  verdict_hit;
    assign miss_pulse = (state == ST_RESULT) && !verdict_hit;
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_move_judge.sv
// Self-checking bench for move_judge: stub generator, scripted/random presser
// and a procedural timeline model compared against the DUT every cycle.
module tb_move_judge;
    import ddr_pkg::*;

    localparam int W = 20;
    localparam int G = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [1:0] move_in;
    logic end_move_in;
    logic get_move, gen_reset, armed, hit_pulse, miss_pulse, done;
    logic [1:0] expected_move;
    logic [7:0] hits, misses, combo, max_combo;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    move_judge #(.WINDOW_CYCLES(W), .GAP_CYCLES(G), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .move_in(move_in), .end_move_in(end_move_in),
        .get_move(get_move), .gen_reset(gen_reset), .expected_move(expected_move),
        .armed(armed), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
        .hits(hits), .misses(misses), .combo(combo), .max_combo(max_combo), .done(done)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        compared++;
        if (act !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s: dut=%0d expected=%0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Stub generator: advances on each get_move rise; seq[k] is the k-th move.
    logic [1:0] seq [0:511];
    int n_moves = 16;
    bit end_en = 1'b1;
    int gcnt = 0;
    logic prev_get = 1'b0;

    assign move_in     = seq[gcnt & 511];
    assign end_move_in = end_en && (gcnt == n_moves);

    initial forever begin
        @(negedge clk);
        if (gen_reset) gcnt = 0;
        else if (get_move && !prev_get) gcnt++;
        prev_get = get_move;
    end

    // Presser: kind 0 none, 1 correct, 2 wrong arrow, 3 correct plus another.
    int kind [0:511];
    int press_at [0:511];
    int mv = 0;
    int acnt = 0;

    task automatic set_btns(input logic [3:0] v);
        {btn_right, btn_left, btn_down, btn_up} = v;
    endtask

    function automatic logic [3:0] press_vec(input int k, input logic [1:0] e);
        logic [1:0] other;
        case (k)
            1: return 4'b0001 << e;
            2: begin other = e + 2'd1; return 4'b0001 << other; end
            3: begin other = e + 2'd2; return (4'b0001 << e) | (4'b0001 << other); end
            default: return 4'b0000;
        endcase
    endfunction

    initial forever begin
        @(negedge clk);
        if (reset || gen_reset) begin
            mv = 0; acnt = 0; set_btns(4'b0000);
        end else if (armed) begin
            acnt++;
            if (acnt == press_at[mv & 511])
                set_btns(press_vec(kind[mv & 511], seq[(mv + 1) & 511]));
        end else begin
            if (acnt != 0) mv++;
            acnt = 0;
            set_btns(4'b0000);
        end
    end

    // Reference model: walks the game timeline one clock at a time.
    int m_hits, m_misses, m_combo, m_max;
    logic [1:0] m_exp;
    bit m_get, m_gen, m_armed, m_hit, m_miss, m_done;
    logic [3:0] r1, r2, r3;
    bit aborted, s_start, s_end;
    logic [1:0] s_move;

    task automatic tick();
        @(posedge clk);
        s_start = start; s_move = move_in; s_end = end_move_in;
        r3 = r2; r2 = r1; r1 = {btn_right, btn_left, btn_down, btn_up};
        if (reset) begin r1 = 0; r2 = 0; r3 = 0; aborted = 1; end
    endtask

    task automatic to_reset();
        m_hits = 0; m_misses = 0; m_combo = 0; m_max = 0; m_exp = 0;
        m_get = 0; m_gen = 1; m_armed = 0; m_hit = 0; m_miss = 0; m_done = 0;
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic play_game();
        bit hit, last;
        int cnt;
        logic [3:0] qe;
        m_gen = 1; m_done = 0; m_armed = 0; m_get = 0; m_hit = 0; m_miss = 0;
        tick(); if (aborted) return;
        m_hits = 0; m_misses = 0; m_combo = 0; m_max = 0;
        forever begin
            m_gen = 0; m_get = 1;
            tick(); if (aborted) return;
            m_get = 0;
            tick(); if (aborted) return;
            tick(); if (aborted) return;
            m_exp = s_move; last = s_end; m_armed = 1; cnt = 0; hit = 0;
            forever begin
                qe = r2 & ~r3;
                if (qe != 0) begin hit = (qe == (4'b0001 << m_exp)); break; end
                if (cnt == W - 1) begin hit = 0; break; end
                tick(); if (aborted) return;
                cnt++;
            end
            tick(); if (aborted) return;
            m_armed = 0; m_hit = hit; m_miss = !hit;
            tick(); if (aborted) return;
            m_hit = 0; m_miss = 0;
            if (hit) begin
                m_hits = sat(m_hits + 1); m_combo = sat(m_combo + 1);
                if (m_combo > m_max) m_max = m_combo;
            end else begin
                m_misses = sat(m_misses + 1); m_combo = 0;
            end
            if (last) begin m_done = 1; return; end
            for (int i = 1; i < G; i++) begin tick(); if (aborted) return; end
            tick(); if (aborted) return;
        end
    endtask

    initial begin
        r1 = 0; r2 = 0; r3 = 0; aborted = 0; to_reset();
        forever begin
            do begin tick(); if (reset) to_reset(); end while (reset || !s_start);
            aborted = 0;
            forever begin
                play_game();
                if (aborted) break;
                do tick(); while (!aborted && !s_start);
                if (aborted) break;
            end
            to_reset();
        end
    end

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            check_output("get_move", get_move, m_get);
            check_output("gen_reset", gen_reset, m_gen);
            check_output("armed", armed, m_armed);
            check_output("hit_pulse", hit_pulse, m_hit);
            check_output("miss_pulse", miss_pulse, m_miss);
            check_output("done", done, m_done);
            check_output("hits", hits, m_hits);
            check_output("misses", misses, m_misses);
            check_output("combo", combo, m_combo);
            check_output("max_combo", max_combo, m_max);
            if (m_armed) check_output("expected_move", expected_move, m_exp);
        end
    end

    task automatic apply_stimulus(input int nm, input bit en, input int k, input int at);
        n_moves = nm; end_en = en;
        for (int i = 0; i < 512; i++) begin
            seq[i] = 2'($urandom_range(0, 3));
            kind[i] = k;
            press_at[i] = at;
        end
    endtask

    task automatic start_game();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (!done && n < max_cycles) begin @(negedge clk); n++; end
        check_output("done_wait", done, 1);
    endtask

    task automatic check_final(input string tag, input int h, input int m, input int c, input int mc);
        check_output({tag, "_hits"}, hits, h);
        check_output({tag, "_misses"}, misses, m);
        check_output({tag, "_combo"}, combo, c);
        check_output({tag, "_max_combo"}, max_combo, mc);
    endtask

    initial begin
        int n;
        apply_stimulus(16, 1, 1, 6);
        repeat (3) @(negedge clk);
        check_output("rst_gen_reset", gen_reset, 1);
        check_output("rst_get_move", get_move, 0);
        check_output("rst_armed", armed, 0);
        check_output("rst_hits", hits, 0);
        check_output("rst_done", done, 0);
        check_output("rst_expected", expected_move, 0);
        #2 reset = 1'b0;

        $display("[TB] all correct presses");
        start_game(); wait_done(2000);
        check_final("a", 16, 0, 16, 16);

        $display("[TB] no presses");
        apply_stimulus(16, 1, 0, 6);
        start_game(); wait_done(2000);
        check_final("b", 0, 16, 0, 0);

        $display("[TB] random presses");
        apply_stimulus(16, 1, 0, 6);
        for (int i = 0; i < 16; i++) begin
            kind[i] = $urandom_range(0, 3);
            press_at[i] = $urandom_range(1, 20);
        end
        start_game(); wait_done(2000);
        check_output("c_total", hits + misses, 16);

        $display("[TB] wrong arrow breaks combo");
        apply_stimulus(5, 1, 1, 6);
        seq[1] = DIR_UP; seq[2] = DIR_DOWN; seq[3] = DIR_LEFT; seq[4] = DIR_UP; seq[5] = DIR_RIGHT;
        kind[3] = 2;
        start_game();
        n = 0;
        while (!miss_pulse && n < 1000) begin @(negedge clk); n++; end
        check_output("d_miss_seen", miss_pulse, 1);
        @(negedge clk);
        check_output("d_combo_cleared", combo, 0);
        check_output("d_max_kept", max_combo, 3);
        wait_done(1000);
        check_final("d", 4, 1, 1, 3);

        $display("[TB] double press and last-cycle press");
        apply_stimulus(2, 1, 1, 6);
        seq[1] = DIR_UP; seq[2] = DIR_UP;
        kind[0] = 3; press_at[1] = 18;
        start_game(); wait_done(1000);
        check_final("e", 1, 1, 1, 1);

        $display("[TB] saturation");
        apply_stimulus(16, 0, 1, 6);
        start_game();
        n = 0;
        begin
            int nh = 0;
            while (nh < 300 && n < 15000) begin
                @(negedge clk); n++;
                if (hit_pulse) nh++;
            end
            check_output("f_hit_pulses", nh, 300);
        end
        @(negedge clk);
        check_final("f", 255, 0, 255, 255);

        $display("[TB] reset mid-game");
        #2 reset = 1'b1;
        @(negedge clk); #2 reset = 1'b0;
        apply_stimulus(16, 0, 1, 6);
        start_game();
        n = 0;
        while (!(hits == 8'd4 && armed) && n < 1000) begin @(negedge clk); n++; end
        check_output("g_reached_hits4", hits, 4);
        #2 reset = 1'b1;
        #1;
        check_final("g", 0, 0, 0, 0);
        check_output("g_armed", armed, 0);
        check_output("g_gen_reset", gen_reset, 1);
        check_output("g_no_pulse", {hit_pulse, miss_pulse}, 0);
        @(negedge clk); #2 reset = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check_output("g_get_early", get_move, 0);
        @(negedge clk);
        check_output("g_get_move", get_move, 1);
        repeat (30) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
